// File: rtl/vec_store_unit.sv
// vec_store_unit: drains one captured multi-lane vector into data memory as
// a sequence of single-word writes, lowest enabled lane first, while holding
// Busy high so the core stalls. All outputs are decoded from registered state.
module vec_store_unit #(
  parameter int LANES  = 5,
  parameter int WIDTH  = 32,
  parameter int STRIDE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            BaseAdr,
  input  logic [LANES-1:0]       LaneMask,
  input  logic [LANES*WIDTH-1:0] VecData,
  input  logic                   MemReady,
  output logic                   MemWrite,
  output logic [31:0]            DataAdr,
  output logic [WIDTH-1:0]       WriteData,
  output logic                   Busy,
  output logic                   Done
);

  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [31:0]              base_q;
  logic [LANES-1:0]         pending_q;
  logic [LANES-1:0]         pending_d;
  logic [LANES*WIDTH-1:0]   vec_q;
  logic [IDXW-1:0]          cur;
  logic [LANES-1:0]         remaining;
  logic [WIDTH-1:0]         lane_words [LANES];

  // State, pending-lane set and the captured vector; capture happens only on an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      pending_q <= '0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (state_q == IDLE && start) begin
        base_q <= BaseAdr;
        vec_q  <= VecData;
      end
    end
  end

  // Lowest set pending bit picks the lane; scanning downward lets the lowest index win
  always_comb begin
    cur = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pending_q[i]) cur = IDXW'(i);
    end
  end

  // Split the captured flat vector into addressable lane words
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_words[i] = vec_q[i*WIDTH +: WIDTH];
    end
  end

  assign remaining = pending_q & ~(LANES'(1) << cur);

  // Next-state and output decode; write outputs stay stable until memory accepts
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pending_d = LaneMask;
          state_d   = (LaneMask != '0) ? WRITE : DONE;
        end
      end
      WRITE: begin
        MemWrite  = 1'b1;
        Busy      = 1'b1;
        DataAdr   = base_q + (32'(STRIDE) * 32'(cur));
        WriteData = lane_words[cur];
        if (MemReady) begin
          pending_d = remaining;
          if (remaining == '0) state_d = DONE;
        end
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vec_store_unit.sv
// tb_vec_store_unit: directed scenario tasks for vec_store_unit, each with
// hand-computed expected write sequences and inline comparisons.
module tb_vec_store_unit;

  logic         clk;
  logic         reset;
  logic         start;
  logic [31:0]  BaseAdr;
  logic [4:0]   LaneMask;
  logic [159:0] VecData;
  logic         MemReady;
  logic         MemWrite;
  logic [31:0]  DataAdr;
  logic [31:0]  WriteData;
  logic         Busy;
  logic         Done;

  int total;
  int bad;

  vec_store_unit #(.LANES(5), .WIDTH(32), .STRIDE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .BaseAdr   (BaseAdr),
    .LaneMask  (LaneMask),
    .VecData   (VecData),
    .MemReady  (MemReady),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .Busy      (Busy),
    .Done      (Done)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a store request on a falling edge so the next rising edge samples it
  task automatic drive_start(input logic [31:0] b, input logic [4:0] m, input logic [159:0] d);
    @(negedge clk);
    start    = 1'b1;
    BaseAdr  = b;
    LaneMask = m;
    VecData  = d;
    MemReady = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    #1;
    total++;
    if ({MemWrite, Busy, Done} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_ctl: got %b want 000", {MemWrite, Busy, Done});
    end
    total++;
    if (DataAdr !== 32'h0 || WriteData !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_data: got adr=%h dat=%h want 0/0", DataAdr, WriteData);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_full_mask();
    logic [2:0] exp_ctl;
    logic [31:0] exp_adr;
    drive_start(32'h100, 5'b11111, {32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start    = 1'b0;
        BaseAdr  = 32'hDEAD0000;
        LaneMask = 5'b00000;
        VecData  = {5{32'hFFFF_FFFF}};
      end
      exp_ctl = (c <= 5) ? 3'b110 : ((c == 6) ? 3'b001 : 3'b000);
      total++;
      if ({MemWrite, Busy, Done} !== exp_ctl) begin
        bad++;
        $display("[TB] FAIL full_ctl cyc%0d: got %b want %b", c, {MemWrite, Busy, Done}, exp_ctl);
      end
      if (c <= 5) begin
        exp_adr = 32'h100 + 32'(4 * (c - 1));
        total++;
        if (DataAdr !== exp_adr || WriteData !== 32'(c)) begin
          bad++;
          $display("[TB] FAIL full_write cyc%0d: got (%h,%h) want (%h,%h)", c, DataAdr, WriteData, exp_adr, 32'(c));
        end
      end
    end
  endtask

  task automatic test_sparse_mask();
    logic [2:0] exp_ctl;
    logic [31:0] exp_adr;
    logic [31:0] exp_dat;
    int writes;
    writes = 0;
    drive_start(32'h40, 5'b10100, {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (MemWrite === 1'b1) writes++;
      exp_ctl = (c <= 2) ? 3'b110 : ((c == 3) ? 3'b001 : 3'b000);
      total++;
      if ({MemWrite, Busy, Done} !== exp_ctl) begin
        bad++;
        $display("[TB] FAIL sparse_ctl cyc%0d: got %b want %b", c, {MemWrite, Busy, Done}, exp_ctl);
      end
      if (c <= 2) begin
        exp_adr = (c == 1) ? 32'h48 : 32'h50;
        exp_dat = (c == 1) ? 32'hA2 : 32'hA4;
        total++;
        if (DataAdr !== exp_adr || WriteData !== exp_dat) begin
          bad++;
          $display("[TB] FAIL sparse_write cyc%0d: got (%h,%h) want (%h,%h)", c, DataAdr, WriteData, exp_adr, exp_dat);
        end
      end
    end
    total++;
    if (writes != 2) begin
      bad++;
      $display("[TB] FAIL sparse_count: got %0d want 2", writes);
    end
  endtask

  task automatic test_backpressure();
    int lane_of [1:8] = '{0, 1, 1, 1, 1, 2, 3, 4};
    logic [2:0] exp_ctl;
    logic [31:0] exp_adr;
    logic [31:0] exp_dat;
    drive_start(32'h200, 5'b11111, {32'h55, 32'h44, 32'h33, 32'h22, 32'h11});
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      exp_ctl = (c <= 8) ? 3'b110 : ((c == 9) ? 3'b001 : 3'b000);
      total++;
      if ({MemWrite, Busy, Done} !== exp_ctl) begin
        bad++;
        $display("[TB] FAIL stall_ctl cyc%0d: got %b want %b", c, {MemWrite, Busy, Done}, exp_ctl);
      end
      if (c <= 8) begin
        exp_adr = 32'h200 + 32'(4 * lane_of[c]);
        exp_dat = 32'(17 * (lane_of[c] + 1));
        total++;
        if (DataAdr !== exp_adr || WriteData !== exp_dat) begin
          bad++;
          $display("[TB] FAIL stall_write cyc%0d: got (%h,%h) want (%h,%h)", c, DataAdr, WriteData, exp_adr, exp_dat);
        end
      end
      MemReady = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic test_mask_zero_and_ignore();
    logic [2:0] exp_ctl;
    logic [31:0] exp_adr;
    logic [31:0] exp_dat;
    drive_start(32'h700, 5'b00000, {5{32'h77}});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      exp_ctl = (c == 1) ? 3'b001 : 3'b000;
      total++;
      if ({MemWrite, Busy, Done} !== exp_ctl) begin
        bad++;
        $display("[TB] FAIL zero_ctl cyc%0d: got %b want %b", c, {MemWrite, Busy, Done}, exp_ctl);
      end
      if (c == 1) begin
        start    = 1'b1;
        BaseAdr  = 32'h800;
        LaneMask = 5'b11111;
      end else begin
        start = 1'b0;
      end
    end
    drive_start(32'h300, 5'b00011, {32'h34, 32'h33, 32'h32, 32'h31, 32'h30});
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_ctl = (c <= 2) ? 3'b110 : ((c == 3) ? 3'b001 : 3'b000);
      total++;
      if ({MemWrite, Busy, Done} !== exp_ctl) begin
        bad++;
        $display("[TB] FAIL ignore_ctl cyc%0d: got %b want %b", c, {MemWrite, Busy, Done}, exp_ctl);
      end
      if (c <= 2) begin
        exp_adr = 32'h300 + 32'(4 * (c - 1));
        exp_dat = 32'h30 + 32'(c - 1);
        total++;
        if (DataAdr !== exp_adr || WriteData !== exp_dat) begin
          bad++;
          $display("[TB] FAIL ignore_write cyc%0d: got (%h,%h) want (%h,%h)", c, DataAdr, WriteData, exp_adr, exp_dat);
        end
      end
      if (c == 1) begin
        BaseAdr  = 32'h900;
        LaneMask = 5'b11111;
        VecData  = {5{32'h99}};
      end
      if (c == 4) start = 1'b0;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_adr [1:5] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 32'h8};
    logic [2:0] exp_ctl;
    drive_start(32'hFFFFFFF8, 5'b11111, {32'hB4, 32'hB3, 32'hB2, 32'hB1, 32'hB0});
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      exp_ctl = (c <= 5) ? 3'b110 : 3'b001;
      total++;
      if ({MemWrite, Busy, Done} !== exp_ctl) begin
        bad++;
        $display("[TB] FAIL wrap_ctl cyc%0d: got %b want %b", c, {MemWrite, Busy, Done}, exp_ctl);
      end
      if (c <= 5) begin
        total++;
        if (DataAdr !== exp_adr[c] || WriteData !== 32'hB0 + 32'(c - 1)) begin
          bad++;
          $display("[TB] FAIL wrap_write cyc%0d: got (%h,%h) want (%h,%h)", c, DataAdr, WriteData, exp_adr[c], 32'hB0 + 32'(c - 1));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_store();
    drive_start(32'h500, 5'b11111, {32'hC4, 32'hC3, 32'hC2, 32'hC1, 32'hC0});
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      total++;
      if (MemWrite !== 1'b1 || DataAdr !== 32'h500 + 32'(4 * (c - 1)) || WriteData !== 32'hC0 + 32'(c - 1)) begin
        bad++;
        $display("[TB] FAIL abort_pre cyc%0d: got (%b,%h,%h) want (1,%h,%h)", c, MemWrite, DataAdr, WriteData,
                 32'h500 + 32'(4 * (c - 1)), 32'hC0 + 32'(c - 1));
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    total++;
    if ({MemWrite, Busy, Done} !== 3'b000 || DataAdr !== 32'h0 || WriteData !== 32'h0) begin
      bad++;
      $display("[TB] FAIL abort_async: got ctl=%b adr=%h dat=%h want 000/0/0", {MemWrite, Busy, Done}, DataAdr, WriteData);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if ({MemWrite, Busy, Done} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL abort_after cyc%0d: got %b want 000", c, {MemWrite, Busy, Done});
      end
    end
    drive_start(32'h600, 5'b00001, {32'hD4, 32'hD3, 32'hD2, 32'hD1, 32'hD0});
    @(negedge clk);
    start = 1'b0;
    total++;
    if (MemWrite !== 1'b1 || DataAdr !== 32'h600 || WriteData !== 32'hD0) begin
      bad++;
      $display("[TB] FAIL restart_write: got (%b,%h,%h) want (1,00000600,000000d0)", MemWrite, DataAdr, WriteData);
    end
    @(negedge clk);
    total++;
    if ({MemWrite, Busy, Done} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL restart_done: got %b want 001", {MemWrite, Busy, Done});
    end
  endtask

  // Scenario sequence
  initial begin
    total    = 0;
    bad      = 0;
    start    = 1'b0;
    BaseAdr  = '0;
    LaneMask = '0;
    VecData  = '0;
    MemReady = 1'b1;
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_backpressure();
    test_mask_zero_and_ignore();
    test_wrap();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
